// File: rtl/mul8_arb_pkg.sv
// Shared constants and operand/product types for the multiplier-sharing arbiter.
package mul8_arb_pkg;

  localparam int unsigned MUL_W        = 8;
  localparam int unsigned PROD_W       = 16;
  localparam int unsigned NREQ_DEFAULT = 4;

  typedef logic signed [MUL_W-1:0]  mul_op_t;
  typedef logic signed [PROD_W-1:0] mul_prod_t;

endpackage

// File: rtl/rr_arbiter.sv
// Wrap-around priority search starting at ptr; returns one-hot grant, its index and an any-grant flag.
module rr_arbiter
  import mul8_arb_pkg::*;
#(
  parameter  int unsigned NREQ = NREQ_DEFAULT,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any
);

  always_comb begin
    int unsigned sum;
    logic [IDW-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    sum       = 0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = 32'(ptr) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      cand = IDW'(sum);
      if (!any && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul8_share_arbiter.sv
// Round-robin sharing of one signed 8x8 multiplier between NREQ requesters, id-tagged responses.
// MUL8_SHARE_ARBITER_BYPASS_S2_EN removes the output register stage (latency 1 instead of 2).
module mul8_share_arbiter
  import mul8_arb_pkg::*;
#(
  parameter  int unsigned NREQ = NREQ_DEFAULT,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*MUL_W-1:0]   req_a,
  input  logic [NREQ*MUL_W-1:0]   req_b,
  output logic                    resp_valid,
  output logic [IDW-1:0]          resp_id,
  output logic [PROD_W-1:0]       resp_prod,
  output logic                    busy
);

  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            any;
  logic            xfer;

  mul_op_t         lane_a [NREQ];
  mul_op_t         lane_b [NREQ];

  mul_op_t         a1, b1;
  logic [IDW-1:0]  id1;
  logic            v1;
  mul_prod_t       prod;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  assign req_ready = rst ? '0 : grant;
  assign xfer      = any & ~rst;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      lane_a[i] = req_a[i*MUL_W +: MUL_W];
      lane_b[i] = req_b[i*MUL_W +: MUL_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (32'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1  <= 1'b0;
      a1  <= '0;
      b1  <= '0;
      id1 <= '0;
    end else begin
      v1 <= xfer;
      if (xfer) begin
        a1  <= lane_a[grant_idx];
        b1  <= lane_b[grant_idx];
        id1 <= grant_idx;
      end
    end
  end

  // Shared signed multiplier; sign-extended operands give the full 16-bit product.
  assign prod = mul_prod_t'(a1) * mul_prod_t'(b1);

`ifdef MUL8_SHARE_ARBITER_BYPASS_S2_EN
  assign resp_valid = v1;
  assign resp_id    = id1;
  assign resp_prod  = prod;
  assign busy       = v1;
`else
  logic v2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2        <= 1'b0;
      resp_id   <= '0;
      resp_prod <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        resp_id   <= id1;
        resp_prod <= prod;
      end
    end
  end

  assign resp_valid = v2;
  assign busy       = v1 | v2;
`endif

endmodule

// File: tb/tb_mul8_share_arbiter.sv
// Scoreboard bench for mul8_share_arbiter: reference grants and products from the arbitration rules.
module tb_mul8_share_arbiter;
  import mul8_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
`ifdef MUL8_SHARE_ARBITER_BYPASS_S2_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*8-1:0]     req_a;
  logic [NREQ*8-1:0]     req_b;
  logic                  resp_valid;
  logic [IDW-1:0]        resp_id;
  logic [15:0]           resp_prod;
  logic                  busy;

  typedef struct {
    int          id;
    logic [15:0] prod;
    int          due;
  } exp_t;

  exp_t            q[$];
  int              total = 0;
  int              bad   = 0;
  int              cyc   = 0;
  int              mptr  = 0;
  bit              chk_en  = 0;
  bit              fair_on = 0;
  int              fair_cnt [NREQ];
  logic [NREQ-1:0] last_gnt;

  mul8_share_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_prod  (resp_prod),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Issue side: expected grant is the first valid lane at or after the model pointer.
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rdy;
    logic signed [7:0] a8, b8;
    int g, idx, p;
    exp_t e;
    if (chk_en) begin
      exp_rdy = '0;
      g = -1;
      if (!rst) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (mptr + k) % NREQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      total++;
      if (req_ready !== exp_rdy) begin
        bad++;
        $display("FAIL ready cyc=%0d got=%b want=%b", cyc, req_ready, exp_rdy);
      end
      if (rst) begin
        mptr = 0;
      end else if (g >= 0) begin
        a8 = req_a[g*8 +: 8];
        b8 = req_b[g*8 +: 8];
        p  = int'(a8) * int'(b8);
        e.id   = g;
        e.prod = p[15:0];
        e.due  = cyc + LAT;
        q.push_back(e);
        mptr = (g + 1) % NREQ;
        if (fair_on) fair_cnt[g]++;
      end
    end
  end

  // Response side: pops the scoreboard whenever the DUT presents a product.
  always @(negedge clk) begin
    int nb;
    exp_t e;
    if (chk_en) begin
      nb = 0;
      foreach (q[i]) if (q[i].due >= cyc && q[i].due < cyc + LAT) nb++;
      total++;
      if (busy !== (nb > 0)) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b want=%0d", cyc, busy, (nb > 0));
      end
      while (q.size() > 0 && q[0].due < cyc) begin
        e = q.pop_front();
        total++; bad++;
        $display("FAIL missing cyc=%0d id=%0d due=%0d", cyc, e.id, e.due);
      end
      if (resp_valid === 1'b1) begin
        total++;
        if (q.size() == 0 || q[0].due != cyc) begin
          bad++;
          $display("FAIL unexpected_resp cyc=%0d got id=%0d prod=%h want no response", cyc, resp_id, resp_prod);
        end else begin
          e = q.pop_front();
          if (resp_id !== IDW'(e.id) || resp_prod !== e.prod) begin
            bad++;
            $display("FAIL resp cyc=%0d got id=%0d prod=%h want id=%0d prod=%h",
                     cyc, resp_id, resp_prod, e.id, e.prod);
          end
        end
      end else if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        total++; bad++;
        $display("FAIL no_resp cyc=%0d got valid=%b want id=%0d prod=%h", cyc, resp_valid, e.id, e.prod);
      end
      if (rst) q.delete();
    end
  end

  task automatic tick();
    @(negedge clk);
    last_gnt = req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input int a, input int b);
    req_a[i*8 +: 8] = 8'(a);
    req_b[i*8 +: 8] = 8'(b);
  endtask

  function automatic int rand_op();
    case ($urandom_range(7))
      0:       return -128;
      1:       return 127;
      2:       return 0;
      default: return int'($urandom_range(255)) - 128;
    endcase
  endfunction

  int ca [4] = '{-128, -128, 127, 0};
  int cb [4] = '{-128,  127, 127, -1};

  initial begin
    clk = 0;
    rst = 1;
    req_valid = '1;
    last_gnt = '0;
    for (int i = 0; i < NREQ; i++) set_lane(i, rand_op(), rand_op());

    // Reset held for three cycles with every lane requesting.
    @(posedge clk); #1;
    chk_en = 1;
    repeat (2) tick();
    rst = 0;
    repeat (4) begin
      tick();
      for (int i = 0; i < NREQ; i++) if (last_gnt[i]) set_lane(i, rand_op(), rand_op());
    end
    req_valid = '0;
    repeat (4) tick();

    // Single request on lane 2: 3 * -5.
    set_lane(2, 3, -5);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    repeat (4) tick();

    // Corner products back-to-back from lane 0.
    for (int j = 0; j < 4; j++) begin
      set_lane(0, ca[j], cb[j]);
      req_valid = 4'b0001;
      tick();
    end
    req_valid = '0;
    repeat (4) tick();

    // Fairness: all lanes continuously valid for 12 cycles.
    for (int i = 0; i < NREQ; i++) fair_cnt[i] = 0;
    req_valid = '1;
    fair_on = 1;
    repeat (12) begin
      tick();
      for (int i = 0; i < NREQ; i++) if (last_gnt[i]) set_lane(i, rand_op(), rand_op());
    end
    fair_on = 0;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      total++;
      if (fair_cnt[i] != 3) begin
        bad++;
        $display("FAIL fair_count lane=%0d got=%0d want=3", i, fair_cnt[i]);
      end
    end
    repeat (4) tick();

    // Reset with lane 1 in flight; afterwards the first grant must go to lane 0.
    set_lane(1, 55, -3);
    req_valid = 4'b0010;
    tick();
    rst = 1;
    req_valid = '1;
    tick();
    rst = 0;
    tick();
    req_valid = '0;
    repeat (5) tick();

    // Randomized traffic honouring the hold-until-ready rule (drops allowed).
    repeat (10000) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && !last_gnt[i]) begin
          if ($urandom_range(7) == 0) req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = 1'($urandom_range(1));
          set_lane(i, rand_op(), rand_op());
        end
      end
    end

    req_valid = '0;
    for (int n = 0; n < 20 && q.size() != 0; n++) tick();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout got=%0d outstanding want=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul8_share_arbiter.md
Name: mul8_share_arbiter

Overview:
- Shares one signed 8x8 Booth/Wallace multiplier (16-bit product) between NREQ independent requesters.
- Round-robin arbitration issues at most one multiply per cycle. Operands and the requester id are registered in front of the multiplier.
- Each product returns on a common response bus tagged with the originating requester id.
- Sits between per-lane posit mantissa units and the shared multiplier instance in the FMAU.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ) (localparam), width of the response id.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester grant; one-hot or zero
- req_a  input  NREQ*8  packed two's-complement multiplicands; lane i is bits [8i+7:8i]
- req_b  input  NREQ*8  packed two's-complement multipliers
- resp_valid  output  1  product valid, single-cycle pulse per accepted request
- resp_id  output  IDW  requester index of the product
- resp_prod  output  16  signed product A*B
- busy  output  1  one or more requests in flight

Behaviour:
- Reset and rst semantics:
  - Clock and reset are decided: one clock, clk; reset rst is synchronous and active-high.
  - On rst, all of the following go to 0 on the next edge: resp_valid, resp_id, resp_prod, busy, the round-robin pointer, and all stage valids.
  - req_ready is 0 while rst is high.
- Arbitration:
  - Search starts at pointer ptr and wraps modulo NREQ. The first i with req_valid[i]=1 is granted.
  - req_ready[i] is a combinational function of req_valid and ptr. It is never asserted for a lane whose req_valid is 0.
  - At most one bit of req_ready is high.
- Handshake:
  - A transfer occurs on the edge where req_valid[i] & req_ready[i].
  - Requesters hold req_valid, req_a and req_b stable until ready. Dropping req_valid before grant is permitted; the request is simply lost.
- Pointer update:
  - After a grant to i, ptr <= (i+1) mod NREQ.
  - If no grant, ptr is unchanged.
  - Fairness bound: a continuously valid requester is granted within NREQ cycles.
- Pipeline stages:
  - S1 registers a, b, id and v1 on the transfer edge. v1 = 0 on cycles with no transfer.
  - The multiplier is combinational from the S1 operands.
  - S2 registers the product, id and v2 from S1.
- Outputs and latency:
  - resp_* are driven from S2. A handshake in cycle t gives resp_valid=1 in cycle t+2.
  - Throughput is 1 per cycle with back-to-back issue.
  - The response has no backpressure. Requesters must accept resp_valid in the cycle it is presented.
- Arithmetic:
  - Full 16-bit signed product, no saturation.
  - Range: -128*-128 = +16384 fits.
- busy = v1 | v2.
- resp_prod and resp_id hold their last value when resp_valid=0. They are don't-care for the checker.
- Boundary conditions:
  - Simultaneous valid on all lanes: exactly one grant per cycle, rotating.
  - Single active lane: granted every cycle regardless of ptr.
  - rst asserted with requests in flight: S1 and S2 are discarded. resp_valid=0 in the cycle after the rst edge. No stale response appears after reset is released.

Optional Feature:
- Macro: MUL8_SHARE_ARBITER_BYPASS_S2_EN.
- Defined: S2 is removed and resp_* are driven combinationally from S1 plus the multiplier. Latency is 1 (handshake in cycle t -> resp_valid in cycle t+1), and busy = v1.
- Undefined (default): 2-cycle registered-output behaviour as above.

Decomposition:
- Package mul8_arb_pkg holds:
  - MUL_W=8 and PROD_W=16 constants
  - typedef logic signed [7:0] mul_op_t
  - typedef logic signed [15:0] mul_prod_t
  - the default NREQ
- Sub-module rr_arbiter (params NREQ; ports req, ptr -> grant one-hot, grant_idx, any):
  - contains the wrap-around priority search
  - the pointer register stays in the top.
- The multiplier is instantiated unchanged as the shared datapath.

Test Plan:
- Reset: hold rst for 3 cycles with all req_valid=1 -> req_ready=0, resp_valid=0 and busy=0 throughout. The first grant after release goes to lane 0.
- Single request: lane 2 sends a=3, b=-5 (0xFB) in cycle t -> resp_valid in t+2 with resp_id=2 and resp_prod=0xFFF1. With BYPASS_S2_EN, the same response arrives in t+1.
- Corners, sent back-to-back from lane 0:
  - -128*-128 -> 0x4000
  - -128*127 -> 0xC080
  - 127*127 -> 0x3F01
  - 0*-1 -> 0x0000
  - Expect four consecutive resp_valid pulses in order.
- Fairness: all four lanes continuously valid for 12 cycles -> grant order 0,1,2,3,0,1,... Each lane gets 3 grants, and resp_id matches the order.
- Reset mid-flight: grant lane 1 in cycle t, assert rst in t+1 -> no resp_valid in t+2 or any later cycle for that request, and ptr=0 after reset.
- Random: 10k cycles of random valid/operands against a scoreboard keyed by issue order -> every accepted request produces exactly one correct, correctly tagged product.
